// File: rtl/h1_block_matlab_imperfect.sv
// Loop-filter H1 of the delta-sigma modulator: direct-form-I biquad on Q1.15
// samples with Q4.12 coefficients, floor truncation and 16-bit output saturation.
module h1_block_matlab_imperfect #(
  parameter logic signed [15:0] B0 = 16'sd0,
  parameter logic signed [15:0] B1 = 16'sd8192,
  parameter logic signed [15:0] B2 = -16'sd4096,
  parameter logic signed [15:0] A1 = 16'sd0,
  parameter logic signed [15:0] A2 = 16'sd0
) (
  input  logic               CLK,
  input  logic [15:0]        reset,
  input  logic signed [15:0] in,
  output logic signed [15:0] out
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 36;
  localparam int SH_W   = ACC_W - 12;

  logic signed [DATA_W-1:0] x1, x2, y1, y2;
  logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] ys;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [SH_W-1:0] v);
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[DATA_W-1:0];
  endfunction

  // Stage 0: products, accumulate, floor-shift (slice drops the low 12 bits) and saturate.
  always_comb begin
    p_b0 = B0 * in;
    p_b1 = B1 * x1;
    p_b2 = B2 * x2;
    p_a1 = A1 * y1;
    p_a2 = A2 * y2;
    acc  = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2) - ACC_W'(p_a1) - ACC_W'(p_a2);
    ys   = sat16(acc[ACC_W-1:12]);
  end

  // Stage 1: output register and filter history; feedback keeps the saturated value.
  always_ff @(posedge CLK) begin
    if (|reset) begin
      x1  <= '0;
      x2  <= '0;
      y1  <= '0;
      y2  <= '0;
      out <= '0;
    end else begin
      x1  <= in;
      x2  <= x1;
      y1  <= ys;
      y2  <= y1;
      out <= ys;
    end
  end

endmodule

// File: tb/tb_h1_block_matlab_imperfect.sv
// Bench for h1_block_matlab_imperfect: default, truncation and integrator
// coefficient sets, each checked against an integer-arithmetic difference-equation model.
module tb_h1_block_matlab_imperfect;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0]        rst_d [3];
  logic signed [15:0] in_d  [3];
  logic signed [15:0] out_d [3];

  // 0: default coefficients, 1: pure gain 0.5, 2: integrator
  h1_block_matlab_imperfect u_def (
    .CLK(CLK), .reset(rst_d[0]), .in(in_d[0]), .out(out_d[0]));
  h1_block_matlab_imperfect #(
    .B0(16'sd2048), .B1(16'sd0), .B2(16'sd0), .A1(16'sd0), .A2(16'sd0)
  ) u_trunc (
    .CLK(CLK), .reset(rst_d[1]), .in(in_d[1]), .out(out_d[1]));
  h1_block_matlab_imperfect #(
    .B0(16'sd4096), .B1(16'sd0), .B2(16'sd0), .A1(-16'sd4096), .A2(16'sd0)
  ) u_integ (
    .CLK(CLK), .reset(rst_d[2]), .in(in_d[2]), .out(out_d[2]));

  int cb0 [3] = '{0, 2048, 4096};
  int cb1 [3] = '{8192, 0, 0};
  int cb2 [3] = '{-4096, 0, 0};
  int ca1 [3] = '{0, 0, -4096};
  int ca2 [3] = '{0, 0, 0};

  // model history: past inputs / outputs as plain integers
  int hx1 [3], hx2 [3], hy1 [3], hy2 [3];
  int expv [3];

  int checks = 0;
  int fails  = 0;

  function automatic int floor_div4096(longint a);
    longint q;
    q = a / 4096;
    if ((a % 4096) != 0 && a < 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Apply current inputs for one rising edge; model and DUT advance together.
  task automatic cycle();
    for (int k = 0; k < 3; k++) begin
      if (rst_d[k] != 16'h0000) begin
        hx1[k] = 0; hx2[k] = 0; hy1[k] = 0; hy2[k] = 0;
        expv[k] = 0;
      end else begin
        longint acc;
        int xn, y;
        xn  = int'(in_d[k]);
        acc = longint'(cb0[k]) * xn + longint'(cb1[k]) * hx1[k] + longint'(cb2[k]) * hx2[k]
            - longint'(ca1[k]) * hy1[k] - longint'(ca2[k]) * hy2[k];
        y = clamp16(floor_div4096(acc));
        hx2[k] = hx1[k]; hx1[k] = xn;
        hy2[k] = hy1[k]; hy1[k] = y;
        expv[k] = y;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(int k);
    rst_d[k] = 16'hFFFF;
    in_d[k]  = 16'sh8560;
    cycle();
    rst_d[k] = 16'h0000;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst_d[k] = 16'hFFFF;
      in_d[k]  = 16'sh8560;
    end
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (out_d[k] !== 16'sh0000) begin
          fails++;
          $display("FAIL reset_hold dut=%0d cyc=%0d got=%h want=0000", k, c, out_d[k]);
        end
      end
    end
    rst_d[0] = 16'h0000;
    cycle();
    checks++;
    if (out_d[0] !== 16'sh0000) begin
      fails++;
      $display("FAIL reset_first_out got=%h want=0000", out_d[0]);
    end
  endtask

  task automatic test_step();
    int want [6] = '{0, 8192, 4096, 4096, 4096, 4096};
    do_reset(0);
    in_d[0] = 16'sh1000;
    for (int n = 0; n < 6; n++) begin
      cycle();
      checks++;
      if (out_d[0] !== 16'(want[n])) begin
        fails++;
        $display("FAIL step n=%0d got=%0d want=%0d", n, out_d[0], want[n]);
      end
    end
  endtask

  task automatic test_saturation();
    int want_p [4] = '{0, 32767, 24576, 24576};
    int want_n [4] = '{0, -32768, -31392, -31392};
    do_reset(0);
    in_d[0] = 16'sh6000;
    for (int n = 0; n < 4; n++) begin
      cycle();
      checks++;
      if (out_d[0] !== 16'(want_p[n])) begin
        fails++;
        $display("FAIL sat_pos n=%0d got=%0d want=%0d", n, out_d[0], want_p[n]);
      end
    end
    do_reset(0);
    in_d[0] = 16'sh8560;
    for (int n = 0; n < 4; n++) begin
      cycle();
      checks++;
      if (out_d[0] !== 16'(want_n[n])) begin
        fails++;
        $display("FAIL sat_neg n=%0d got=%0d want=%0d", n, out_d[0], want_n[n]);
      end
    end
  endtask

  task automatic test_truncation();
    logic [15:0] stim [3] = '{16'hFFFF, 16'h0001, 16'h2D90};
    logic [15:0] want [3] = '{16'hFFFF, 16'h0000, 16'h16C8};
    do_reset(1);
    for (int n = 0; n < 3; n++) begin
      in_d[1] = stim[n];
      cycle();
      checks++;
      if (out_d[1] !== want[n]) begin
        fails++;
        $display("FAIL trunc n=%0d got=%h want=%h", n, out_d[1], want[n]);
      end
    end
  endtask

  task automatic test_integrator();
    int w;
    do_reset(2);
    in_d[2] = 16'sh0100;
    for (int n = 1; n <= 135; n++) begin
      cycle();
      w = (256 * n > 32767) ? 32767 : 256 * n;
      checks++;
      if (out_d[2] !== 16'(w)) begin
        fails++;
        $display("FAIL integ n=%0d got=%0d want=%0d", n, out_d[2], w);
      end
    end
    // mid-stream reset discards the saturated history
    rst_d[2] = 16'h0001;
    cycle();
    checks++;
    if (out_d[2] !== 16'sh0000) begin
      fails++;
      $display("FAIL integ_midreset got=%0d want=0", out_d[2]);
    end
    rst_d[2] = 16'h0000;
    for (int n = 1; n <= 4; n++) begin
      cycle();
      checks++;
      if (out_d[2] !== 16'(256 * n)) begin
        fails++;
        $display("FAIL integ_restart n=%0d got=%0d want=%0d", n, out_d[2], 256 * n);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        in_d[k]  = 16'($urandom);
        rst_d[k] = ($urandom_range(0, 39) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000;
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (out_d[k] !== 16'(expv[k])) begin
          fails++;
          $display("FAIL random dut=%0d cyc=%0d got=%0d want=%0d", k, c, out_d[k], expv[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_d[k] = 16'hFFFF;
      in_d[k]  = 16'sh0000;
      hx1[k] = 0; hx2[k] = 0; hy1[k] = 0; hy2[k] = 0; expv[k] = 0;
    end
    @(negedge CLK);
    test_reset();
    test_step();
    test_saturation();
    test_truncation();
    test_integrator();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
